// File: rtl/gpu_launch_sched.sv
// gpu_launch_sched: queues GEMM-style launch descriptors and hands them to a
// single compute core one at a time (launch pulse, wait for busy, wait for done).
// Optional watchdog built only when GPU_LAUNCH_TIMEOUT_EN is defined; without it
// err_timeout is tied low and tmo_limit is ignored.
module gpu_launch_sched #(
  parameter int QDEPTH = 4,
  parameter int QAW    = 2,
  parameter int TMO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_a_base,
  input  logic [31:0]      job_b_base,
  input  logic [31:0]      job_c_base,
  input  logic [31:0]      job_n_words,
  output logic [31:0]      core_a_base,
  output logic [31:0]      core_b_base,
  output logic [31:0]      core_c_base,
  output logic [31:0]      core_n_words,
  output logic             core_start,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic             abort,
  input  logic [TMO_W-1:0] tmo_limit,
  output logic             sched_busy,
  output logic [QAW:0]     q_count,
  output logic [15:0]      jobs_done,
  output logic             err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, RUN} state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] mem_a [QDEPTH];
  logic [31:0] mem_b [QDEPTH];
  logic [31:0] mem_c [QDEPTH];
  logic [31:0] mem_n [QDEPTH];

  logic [QAW-1:0] wr_ptr;
  logic [QAW-1:0] rd_ptr;
  logic [QAW:0]   count;
  logic           full;
  logic           push;
  logic           pop;
  logic           timeout;
  logic           job_finish;

  // abort blocks both the push and the pop so a flush really empties the queue
  assign full       = (count == (QAW+1)'(QDEPTH));
  assign job_ready  = !full && !abort;
  assign push       = job_valid && job_ready;
  assign pop        = (state == IDLE) && (count != '0) && !abort;
  assign q_count    = count;
  assign sched_busy = (state != IDLE);
  assign core_start = (state == LAUNCH) && !abort;
  assign job_finish = (state == RUN) && !abort && !timeout && !core_busy && core_done;

  // Descriptor storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= job_a_base;
      mem_b[wr_ptr] <= job_b_base;
      mem_c[wr_ptr] <= job_c_base;
      mem_n[wr_ptr] <= job_n_words;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at QDEPTH
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QAW'(1);
      if (pop)  rd_ptr <= rd_ptr + QAW'(1);
      case ({push, pop})
        2'b10:   count <= count + (QAW+1)'(1);
        2'b01:   count <= count - (QAW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Launch sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: abort wins everywhere, watchdog beats a late done
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (count != '0) state_nxt = LAUNCH;
        LAUNCH:    state_nxt = WAIT_BUSY;
        WAIT_BUSY: begin
          if (timeout)        state_nxt = IDLE;
          else if (core_busy) state_nxt = RUN;
        end
        RUN:       if (timeout || (!core_busy && core_done)) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Active descriptor presented to the core, held from one pop to the next
  always_ff @(posedge clk) begin
    if (rst) begin
      core_a_base  <= '0;
      core_b_base  <= '0;
      core_c_base  <= '0;
      core_n_words <= '0;
    end else if (pop) begin
      core_a_base  <= mem_a[rd_ptr];
      core_b_base  <= mem_b[rd_ptr];
      core_c_base  <= mem_c[rd_ptr];
      core_n_words <= mem_n[rd_ptr];
    end
  end

  // Completed-job counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst)             jobs_done <= '0;
    else if (job_finish) jobs_done <= jobs_done + 16'd1;
  end

`ifdef GPU_LAUNCH_TIMEOUT_EN
  logic [TMO_W-1:0] wd_cnt;
  logic [TMO_W:0]   wd_next;
  logic             in_wait;
  logic             err_q;

  // timeout fires in the cycle that would be the tmo_limit-th spent waiting
  assign in_wait     = (state == WAIT_BUSY) || (state == RUN);
  assign wd_next     = {1'b0, wd_cnt} + (TMO_W+1)'(1);
  assign timeout     = in_wait && (tmo_limit != '0) && (wd_next >= {1'b0, tmo_limit});
  assign err_timeout = err_q;

  // Watchdog counter, restarted whenever a new job is popped for launch
  always_ff @(posedge clk) begin
    if (rst)          wd_cnt <= '0;
    else if (pop)     wd_cnt <= '0;
    else if (in_wait) wd_cnt <= wd_next[TMO_W-1:0];
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                    err_q <= 1'b0;
    else if (timeout && !abort) err_q <= 1'b1;
  end
`else
  logic unused_tmo;

  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_tmo  = ^tmo_limit;
`endif

endmodule

// File: tb/tb_gpu_launch_sched.sv
// tb_gpu_launch_sched: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the launch scheduler.
// Honours GPU_LAUNCH_TIMEOUT_EN the same way the design does.
module tb_gpu_launch_sched;

  localparam int QDEPTH = 4;
  localparam int QAW    = 2;
  localparam int TMO_W  = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] n;
  } desc_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [31:0]      job_a_base, job_b_base, job_c_base, job_n_words;
  logic [31:0]      core_a_base, core_b_base, core_c_base, core_n_words;
  logic             core_start;
  logic             core_busy;
  logic             core_done;
  logic             abort;
  logic [TMO_W-1:0] tmo_limit;
  logic             sched_busy;
  logic [QAW:0]     q_count;
  logic [15:0]      jobs_done;
  logic             err_timeout;

  gpu_launch_sched #(.QDEPTH(QDEPTH), .QAW(QAW), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_base(job_a_base), .job_b_base(job_b_base),
    .job_c_base(job_c_base), .job_n_words(job_n_words),
    .core_a_base(core_a_base), .core_b_base(core_b_base),
    .core_c_base(core_c_base), .core_n_words(core_n_words),
    .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
    .abort(abort), .tmo_limit(tmo_limit),
    .sched_busy(sched_busy), .q_count(q_count),
    .jobs_done(jobs_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: pending descriptors, whether a job is out at the core,
  // whether its launch pulse is due, and whether the core has shown busy yet
  desc_t       mq[$];
  desc_t       cur;
  bit          m_out;
  bit          m_launch;
  bit          m_seen_busy;
  bit          m_err;
  int          m_wd;
  logic [15:0] m_done;
  bit          last_start;
  logic [31:0] start_log[$];

  desc_t nodesc;
  desc_t jd;
  int    cphase, pre, run;
  logic  rv, rab, rbz, rdn;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  // one clock cycle: drive inputs, compare all outputs to the model, advance the model
  task automatic applyStimulus(input logic v, input desc_t d, input logic ab,
                               input logic bz, input logic dn, input logic r);
    bit exp_ready, do_push, do_pop, active, tmo;
    @(negedge clk);
    rst = r; job_valid = v; abort = ab; core_busy = bz; core_done = dn;
    job_a_base = d.a; job_b_base = d.b; job_c_base = d.c; job_n_words = d.n;
    #1;
    exp_ready  = (mq.size() < QDEPTH) && !ab;
    last_start = m_launch && !ab;
    checkOutput("job_ready",    32'(job_ready),   32'(exp_ready));
    checkOutput("q_count",      32'(q_count),     32'(mq.size()));
    checkOutput("core_start",   32'(core_start),  32'(last_start));
    checkOutput("sched_busy",   32'(sched_busy),  32'(m_out));
    checkOutput("jobs_done",    32'(jobs_done),   32'(m_done));
    checkOutput("err_timeout",  32'(err_timeout), 32'(m_err));
    checkOutput("core_a_base",  core_a_base,  cur.a);
    checkOutput("core_b_base",  core_b_base,  cur.b);
    checkOutput("core_c_base",  core_c_base,  cur.c);
    checkOutput("core_n_words", core_n_words, cur.n);
    if (core_start === 1'b1) start_log.push_back(core_a_base);

    if (r) begin
      mq.delete(); cur = '0; m_out = 0; m_launch = 0; m_seen_busy = 0;
      m_err = 0; m_wd = 0; m_done = '0;
    end else if (ab) begin
      mq.delete(); m_out = 0; m_launch = 0; m_seen_busy = 0;
    end else begin
      do_push = v && exp_ready;
      do_pop  = !m_out && (mq.size() > 0);
      active  = m_out && !m_launch;
      tmo     = 0;
`ifdef GPU_LAUNCH_TIMEOUT_EN
      if (active && (tmo_limit != '0) && (m_wd + 1 >= int'(tmo_limit))) tmo = 1;
      if (active) m_wd++;
`endif
      if (tmo) begin
        m_err = 1; m_out = 0;
      end else if (active && m_seen_busy && !bz && dn) begin
        m_done = m_done + 16'd1; m_out = 0;
      end else if (active && bz) begin
        m_seen_busy = 1;
      end
      m_launch = 0;
      if (do_pop) begin
        cur = mq.pop_front(); m_out = 1; m_launch = 1; m_seen_busy = 0; m_wd = 0;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  task automatic idleCycles(input int n, input logic bz, input logic dn);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, nodesc, 1'b0, bz, dn, 1'b0);
  endtask

  // bounded wait for the next launch pulse with the core quiet
  task automatic waitStart(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b0, 1'b0);
      seen = last_start;
    end
    if (!seen) checkOutput(tag, 32'd0, 32'd1);
  endtask

  initial begin
    nodesc = '0;
    rst = 1'b1; job_valid = 0; abort = 0; core_busy = 0; core_done = 0;
    job_a_base = 0; job_b_base = 0; job_c_base = 0; job_n_words = 0;
    tmo_limit = '0;
    cur = '0; m_out = 0; m_launch = 0; m_seen_busy = 0; m_err = 0; m_wd = 0; m_done = '0;
    repeat (3) @(posedge clk);

    // reset state observed through the per-cycle comparison
    idleCycles(2, 1'b0, 1'b0);

    // single job: launch two cycles after the push, busy 10 cycles, then done
    jd = '{a: 32'h0, b: 32'h40, c: 32'h80, n: 32'h8};
    applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(1, 1'b0, 1'b0);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_start",   32'(core_start), 32'd1);
    checkOutput("t2_a_base",  core_a_base,     32'h0);
    checkOutput("t2_n_words", core_n_words,    32'h8);
    idleCycles(10, 1'b1, 1'b0);
    idleCycles(1, 1'b0, 1'b1);
    idleCycles(1, 1'b0, 1'b0);
    checkOutput("single_done", 32'(jobs_done),  32'd1);
    checkOutput("single_idle", 32'(sched_busy), 32'd0);

    // five back-to-back pushes with a stalled core: fills the queue, FIFO order
    start_log.delete();
    for (int k = 0; k < 5; k++) begin
      jd = '{a: 32'(k) * 32'h100, b: 32'h1, c: 32'h2, n: 32'(k)};
      applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, nodesc, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ready", 32'(job_ready), 32'd0);
    checkOutput("full_count", 32'(q_count),   32'd4);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) waitStart("burst_launch_timeout");
      idleCycles(2, 1'b1, 1'b0);
      idleCycles(1, 1'b0, 1'b1);
    end
    idleCycles(1, 1'b0, 1'b0);
    checkOutput("burst_done",  32'(jobs_done),        32'd6);
    checkOutput("burst_count", 32'(start_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < start_log.size(); k++)
      checkOutput("burst_order", start_log[k], 32'(k) * 32'h100);

    // abort in RUN with three queued and job_valid held high
    jd = '{a: 32'hA000, b: 32'h1, c: 32'h2, n: 32'h3};
    applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("abort_launch_timeout");
    idleCycles(1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      jd = '{a: 32'hB000 + 32'(k), b: 32'h0, c: 32'h0, n: 32'h1};
      applyStimulus(1'b1, jd, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    start_log.delete();
    applyStimulus(1'b1, jd, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_ready", 32'(job_ready), 32'd0);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_count", 32'(q_count),    32'd0);
    checkOutput("abort_idle",  32'(sched_busy), 32'd0);
    idleCycles(4, 1'b0, 1'b1);
    checkOutput("abort_nostart", 32'(start_log.size()), 32'd0);
    checkOutput("abort_done",    32'(jobs_done),        32'd6);

    // watchdog: core never reports busy
    tmo_limit = 16'd20;
    jd = '{a: 32'hC000, b: 32'h0, c: 32'h0, n: 32'h4};
    applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("tmo_launch_timeout");
`ifdef GPU_LAUNCH_TIMEOUT_EN
    jd = '{a: 32'hD000, b: 32'h0, c: 32'h0, n: 32'h5};
    applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    idleCycles(19, 1'b0, 1'b0);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_err",  32'(err_timeout), 32'd1);
    checkOutput("tmo_idle", 32'(sched_busy),  32'd0);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tmo_next_start", 32'(core_start), 32'd1);
    checkOutput("tmo_next_a",     core_a_base,     32'hD000);
`else
    idleCycles(40, 1'b0, 1'b0);
    checkOutput("notmo_busy", 32'(sched_busy),  32'd1);
    checkOutput("notmo_err",  32'(err_timeout), 32'd0);
`endif
    checkOutput("tmo_jobs", 32'(jobs_done), 32'd6);
    tmo_limit = '0;
    applyStimulus(1'b0, nodesc, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a running job with another queued
    jd = '{a: 32'hE000, b: 32'h7, c: 32'h8, n: 32'h9};
    applyStimulus(1'b1, jd, 1'b0, 1'b0, 1'b0, 1'b0);
    waitStart("rst_launch_timeout");
    idleCycles(2, 1'b1, 1'b0);
    applyStimulus(1'b1, jd, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, nodesc, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_busy",  32'(sched_busy),  32'd0);
    checkOutput("rst_count", 32'(q_count),     32'd0);
    checkOutput("rst_a",     core_a_base,      32'd0);
    checkOutput("rst_jobs",  32'(jobs_done),   32'd0);
    checkOutput("rst_err",   32'(err_timeout), 32'd0);

    // randomized traffic with a behavioural core (occasional long stalls)
    tmo_limit = 16'd15;
    cphase = 0; pre = 0; run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (cphase)
        1:       begin rbz = 1'b0; rdn = ($urandom_range(3) == 0); end
        2:       begin rbz = 1'b1; rdn = $urandom_range(1) == 1; end
        3:       begin rbz = 1'b0; rdn = 1'b1; end
        default: begin rbz = 1'b0; rdn = 1'b0; end
      endcase
      rv  = $urandom_range(1) == 1;
      rab = ($urandom_range(63) == 0);
      jd  = '{a: $urandom, b: $urandom, c: $urandom, n: $urandom};
      applyStimulus(rv, jd, rab, rbz, rdn, 1'b0);
      if (last_start) begin
        cphase = 1;
        pre    = ($urandom_range(7) == 0) ? 25 : int'($urandom_range(3));
        run    = 1 + int'($urandom_range(5));
      end else begin
        case (cphase)
          1:       if (pre == 0) cphase = 2; else pre--;
          2:       if (run <= 1) cphase = 3; else run--;
          3:       cphase = 0;
          default: cphase = 0;
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_launch_sched.md
GPU_LAUNCH_SCHED -- requirements
Module: gpu_launch_sched

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: launch-descriptor queue depth (power of two).
REQ-002 SHALL have parameter QAW, default 2: log2(QDEPTH).
REQ-003 SHALL have parameter TMO_W, default 16: width of the watchdog counter and of tmo_limit.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports job_valid (input, 1) and job_ready (output, 1): descriptor push handshake.
REQ-007 SHALL have inputs job_a_base, job_b_base, job_c_base and job_n_words, each 32 bits: descriptor fields.
REQ-008 SHALL have outputs core_a_base, core_b_base, core_c_base and core_n_words, each 32 bits: active descriptor driven to the core.
REQ-009 SHALL have output core_start, 1: one-cycle launch pulse to the core.
REQ-010 SHALL have inputs core_busy and core_done, each 1: core status.
REQ-011 SHALL have input abort, 1: flushes the queue and returns the block to IDLE.
REQ-012 SHALL have input tmo_limit, TMO_W: watchdog limit in cycles; 0 disables the watchdog.
REQ-013 SHALL have output sched_busy, 1: high when the state is not IDLE.
REQ-014 SHALL have output q_count, QAW+1: queue occupancy.
REQ-015 SHALL have output jobs_done, 16: count of completed jobs.
REQ-016 SHALL have output err_timeout, 1: sticky watchdog flag.

Function
REQ-017 Push SHALL occur on job_valid && job_ready; job_ready = !full && !abort.
REQ-018 Queue SHALL be FIFO-ordered; a push into an empty queue at cycle t SHALL be poppable at t+1.
REQ-019 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, RUN.
REQ-020 IDLE: when q_count>0, pop the head into core_* registers and go to LAUNCH.
REQ-021 LAUNCH: core_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: on core_busy=1, go to RUN.
REQ-023 RUN: on core_busy=0 && core_done=1, increment jobs_done and go to IDLE.
REQ-024 Launch latency: a job pushed into an empty, idle block at cycle t SHALL see core_start high at cycle t+2.
REQ-025 core_* descriptor outputs SHALL hold their values from pop until the next pop.
REQ-026 Push and pop in the same cycle SHALL leave q_count unchanged; pointers SHALL wrap modulo QDEPTH.
REQ-027 jobs_done SHALL wrap from 0xFFFF to 0.
REQ-028 abort SHALL take priority in every state: next state IDLE, queue emptied, no core_start, and any same-cycle push dropped.
REQ-029 Only one job SHALL be outstanding at the core at any time.

Reset
REQ-030 On rst: state IDLE, queue empty, core_start=0, core_* descriptor outputs=0, jobs_done=0, err_timeout=0, watchdog counter=0.
REQ-031 rst asserted mid-job SHALL discard the queue and the in-flight job without incrementing jobs_done.

Configuration
REQ-032 Macro GPU_LAUNCH_TIMEOUT_EN defined: a watchdog counter SHALL count cycles spent in WAIT_BUSY/RUN and clear on entering LAUNCH.
REQ-033 With the macro defined: when tmo_limit!=0 and the count reaches tmo_limit, err_timeout SHALL be set (sticky until rst), jobs_done SHALL not increment, and the state SHALL return to IDLE.
REQ-034 Macro GPU_LAUNCH_TIMEOUT_EN undefined: no counter is built, err_timeout SHALL be tied to 0, and tmo_limit SHALL be ignored.

Verification
REQ-035 Push one job (a=0,b=0x40,c=0x80,n=8) into an idle block -> core_start at t+2 with core_a_base=0 and core_n_words=8; model busy for 10 cycles then done -> jobs_done=1, sched_busy=0.
REQ-036 Push 5 jobs back-to-back with QDEPTH=4 and the core stalled -> job_ready=0 once full; jobs launch in push order; jobs_done=5 after all complete.
REQ-037 Hold job_valid high and assert abort during RUN with 3 jobs queued -> q_count=0 the next cycle, state IDLE, no further core_start, jobs_done unchanged.
REQ-038 With GPU_LAUNCH_TIMEOUT_EN defined and tmo_limit=20, core never asserts busy -> err_timeout=1 after 20 cycles, next queued job launches; with the macro undefined -> block waits indefinitely.
REQ-039 Assert rst mid-RUN -> all outputs at reset values on the following cycle.
